// File: rtl/pc_unit.sv
// pc_unit: program counter for the Hmmm core.
// Supports increment, absolute jump, signed relative branch and call/return
// through a small internal return-address stack. Shares a tri-state data bus
// with the rest of the core: it drives the PC onto the bus on request and
// samples jump/branch/call operands from it.
module pc_unit #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              increment,
   input  logic              jump,
   input  logic              branch,
   input  logic              call,
   input  logic              ret,
   input  logic              pc_out,
   input  logic              clr_err,
   inout  wire  [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] pc,
   output logic              stack_empty,
   output logic              stack_full,
   output logic              err_ovf,
   output logic              err_unf
);

   // Stack pointer counts occupied entries (0 .. STACK_DEPTH), so it needs
   // one more code than the entry index does.
   localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
   localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   // Next sequential address, wrapping at the top of the address space.
   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
      return a + ADDR_W'(1);
   endfunction

   // Relative target: current PC plus a two's complement offset, modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] wrap_offset(input logic [ADDR_W-1:0] a,
                                                     input logic signed [ADDR_W-1:0] off);
      logic signed [ADDR_W-1:0] base;
      logic signed [ADDR_W-1:0] sum;
      base = $signed(a);
      sum  = base + off;
      return $unsigned(sum);
   endfunction

   logic [ADDR_W-1:0]        stack [STACK_DEPTH];
   logic [SP_W-1:0]          sp;

   logic [ADDR_W-1:0]        operand;
   logic signed [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0]        pc_inc;
   logic [ADDR_W-1:0]        ret_addr;
   logic [SP_W-1:0]          sp_dec;
   logic [ADDR_W-1:0]        pc_next;

   logic                     do_ret;
   logic                     do_call;
   logic                     do_jump;
   logic                     do_branch;
   logic                     do_inc;
   logic                     push;
   logic                     pop;
   logic                     ovf_evt;
   logic                     unf_evt;

   logic                     bus_drive;
   logic [DATA_W-1:0]        bus_word;

   // Upper bus bits carry no operand information; folding them here keeps
   // the whole bus visibly consumed.
   logic                     unused_bus;
   assign unused_bus = ^data;

   assign stack_empty = (sp == '0);
   assign stack_full  = (sp == SP_FULL);

   assign operand  = data[ADDR_W-1:0];
   assign offset   = $signed(operand);
   assign pc_inc   = wrap_inc(pc);
   assign sp_dec   = sp - SP_W'(1);
   assign ret_addr = stack[sp_dec[IDX_W-1:0]];

   // Priority decode (ret > call > jump > branch > increment) and next-PC select.
   always_comb begin
      do_ret    = ret;
      do_call   = call & ~ret;
      do_jump   = jump & ~ret & ~call;
      do_branch = branch & ~ret & ~call & ~jump;
      do_inc    = increment & ~ret & ~call & ~jump & ~branch;

      push      = do_call & ~stack_full;
      pop       = do_ret & ~stack_empty;
      ovf_evt   = do_call & stack_full;
      unf_evt   = do_ret & stack_empty;

      pc_next   = pc;
      if (pop) begin
         pc_next = ret_addr;
      end else if (push) begin
         pc_next = operand;
      end else if (do_jump) begin
         pc_next = operand;
      end else if (do_branch) begin
         pc_next = wrap_offset(pc, offset);
      end else if (do_inc) begin
         pc_next = pc_inc;
      end
   end

   // Bus word is the PC zero-extended to the bus width; the PC stays off the
   // bus whenever a command is using it as an operand, and during reset.
   always_comb begin
      bus_word             = '0;
      bus_word[ADDR_W-1:0] = pc;
      bus_drive            = rst & pc_out & ~(jump | branch | call);
   end

   assign data = bus_drive ? bus_word : {DATA_W{1'bz}};

   // Control state: PC, stack pointer and sticky error flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc      <= '0;
         sp      <= '0;
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else begin
         pc <= pc_next;
         if (push) begin
            sp <= sp + SP_W'(1);
         end else if (pop) begin
            sp <= sp_dec;
         end
         // A new error in the same cycle as clr_err leaves the flag set.
         err_ovf <= (err_ovf & ~clr_err) | ovf_evt;
         err_unf <= (err_unf & ~clr_err) | unf_evt;
      end
   end

   // Return-address storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push) begin
         stack[sp[IDX_W-1:0]] <= pc_inc;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed test-plan sequences plus randomized commands,
// checked by a scoreboard against a queue-based behavioural model.
module tb_pc_unit;

   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 16;
   localparam int STACK_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              increment, jump, branch, call, ret, pc_out, clr_err;
   wire  [DATA_W-1:0] data;
   logic [ADDR_W-1:0] pc;
   logic              stack_empty, stack_full, err_ovf, err_unf;

   logic [DATA_W-1:0] tb_bus;
   logic              tb_en;

   // Bench drives operands; an undriven bus floats high through the pull-up,
   // and the PC's zero-extension can never produce all ones.
   assign data = tb_en ? tb_bus : {DATA_W{1'bz}};
   pullup (data);

   localparam logic [DATA_W-1:0] BUS_IDLE = {DATA_W{1'b1}};

   pc_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) dut (
      .clk(clk), .rst(rst), .increment(increment), .jump(jump), .branch(branch),
      .call(call), .ret(ret), .pc_out(pc_out), .clr_err(clr_err), .data(data),
      .pc(pc), .stack_empty(stack_empty), .stack_full(stack_full),
      .err_ovf(err_ovf), .err_unf(err_unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] bus;
      logic [ADDR_W-1:0] pc;
      logic              empty;
      logic              full;
      logic              ovf;
      logic              unf;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   int m_pc;
   int m_stack[$];
   bit m_ovf, m_unf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_reset();
      m_pc = 0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
   endfunction

   function automatic void model_step(input bit r, c, j, b, inc, clr, input int opnd);
      bit new_ovf = 0;
      bit new_unf = 0;
      int off;
      if (r) begin
         if (m_stack.size() == 0) new_unf = 1;
         else m_pc = m_stack.pop_back();
      end else if (c) begin
         if (m_stack.size() == STACK_DEPTH) new_ovf = 1;
         else begin
            m_stack.push_back((m_pc + 1) % 256);
            m_pc = opnd;
         end
      end else if (j) begin
         m_pc = opnd;
      end else if (b) begin
         off  = (opnd >= 128) ? opnd - 256 : opnd;
         m_pc = (m_pc + off + 256) % 256;
      end else if (inc) begin
         m_pc = (m_pc + 1) % 256;
      end
      m_ovf = (m_ovf && !clr) || new_ovf;
      m_unf = (m_unf && !clr) || new_unf;
   endfunction

   // Issue one command cycle and push what the DUT should show for it.
   task automatic cycle(input bit r, c, j, b, inc, po, clr, input logic [7:0] opnd);
      exp_t e;
      @(negedge clk);
      ret = r; call = c; jump = j; branch = b; increment = inc;
      pc_out = po; clr_err = clr;
      tb_en  = c | j | b;
      tb_bus = {8'($urandom_range(0, 255)), opnd};
      if (c | j | b)  e.bus = tb_bus;
      else if (po)    e.bus = {8'h00, 8'(m_pc)};
      else            e.bus = BUS_IDLE;
      model_step(r, c, j, b, inc, clr, int'(opnd));
      e.pc    = 8'(m_pc);
      e.empty = (m_stack.size() == 0);
      e.full  = (m_stack.size() == STACK_DEPTH);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      exp_q.push_back(e);
   endtask

   task automatic idle(input bit po);
      cycle(0, 0, 0, 0, 0, po, 0, 8'h00);
   endtask

   // Assert reset between clock edges with a command pending; PC must clear at once.
   task automatic mid_reset();
      @(negedge clk);
      increment = 1'b1; pc_out = 1'b1; jump = 0; branch = 0; call = 0; ret = 0;
      clr_err = 0; tb_en = 0;
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      chk("reset_pc_async", 32'(pc), 32'(m_pc));
      chk("reset_empty", 32'(stack_empty), 32'd1);
      chk("reset_full", 32'(stack_full), 32'd0);
      chk("reset_err_ovf", 32'(err_ovf), 32'd0);
      chk("reset_err_unf", 32'(err_unf), 32'd0);
      chk("reset_bus_released", 32'(data), 32'(BUS_IDLE));
      @(posedge clk);
      #1;
      chk("reset_hold_pc", 32'(pc), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      increment = 0; pc_out = 0;
   endtask

   // Monitor: bus is checked mid-cycle, registered state just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("bus", 32'(data), 32'(e.bus));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("pc", 32'(pc), 32'(e.pc));
            chk("stack_empty", 32'(stack_empty), 32'(e.empty));
            chk("stack_full", 32'(stack_full), 32'(e.full));
            chk("err_ovf", 32'(err_ovf), 32'(e.ovf));
            chk("err_unf", 32'(err_unf), 32'(e.unf));
         end
      end
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      bit r, c, j, b, inc, po, clr;
      rst = 1'b0; increment = 0; jump = 0; branch = 0; call = 0; ret = 0;
      pc_out = 0; clr_err = 0; tb_en = 0; tb_bus = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      mid_reset();

      // Reset and increment with pc_out: bus shows 0, 1, 2
      repeat (3) cycle(0, 0, 0, 0, 1, 1, 0, 8'h00);
      idle(0);

      // Jump with pc_out suppressed
      cycle(0, 0, 1, 0, 0, 0, 0, 8'd5);
      cycle(0, 0, 1, 0, 0, 1, 0, 8'd42);
      idle(1);

      // Branch with wrap
      cycle(0, 0, 1, 0, 0, 0, 0, 8'd10);
      cycle(0, 0, 0, 1, 0, 1, 0, 8'hFB);
      cycle(0, 0, 1, 0, 0, 0, 0, 8'd250);
      cycle(0, 0, 0, 1, 0, 0, 0, 8'd10);
      // Increment wrap 255 -> 0
      cycle(0, 0, 1, 0, 0, 0, 0, 8'd255);
      cycle(0, 0, 0, 0, 1, 1, 0, 8'h00);

      // Call/return nesting
      mid_reset();
      cycle(0, 0, 1, 0, 0, 0, 0, 8'd3);
      cycle(0, 1, 0, 0, 0, 0, 0, 8'd20);
      cycle(0, 1, 0, 0, 0, 0, 0, 8'd40);
      cycle(0, 1, 0, 0, 0, 0, 0, 8'd60);
      cycle(0, 1, 0, 0, 0, 0, 0, 8'd80);
      cycle(0, 1, 0, 0, 0, 0, 0, 8'd99);   // overflow
      repeat (4) cycle(1, 0, 0, 0, 0, 1, 0, 8'h00);
      cycle(1, 0, 0, 0, 0, 0, 0, 8'h00);   // underflow
      idle(0);
      idle(1);
      cycle(1, 0, 0, 0, 0, 0, 1, 8'h00);   // new underflow wins over clr_err
      cycle(0, 0, 0, 0, 0, 0, 1, 8'h00);

      // Priority
      cycle(0, 1, 0, 0, 0, 0, 0, 8'd30);
      cycle(1, 1, 0, 0, 1, 0, 0, 8'd77);
      cycle(0, 1, 1, 1, 1, 1, 0, 8'd50);
      cycle(1, 0, 0, 0, 0, 0, 0, 8'h00);
      cycle(0, 0, 1, 1, 0, 0, 0, 8'd120);
      cycle(0, 0, 0, 1, 1, 0, 0, 8'd3);
      // Back-to-back call and ret
      cycle(0, 1, 0, 0, 0, 0, 0, 8'd100);
      cycle(1, 0, 0, 0, 0, 1, 0, 8'h00);
      cycle(0, 0, 0, 0, 1, 0, 0, 8'h00);
      mid_reset();

      // Randomized commands
      for (int k = 0; k < 400; k++) begin
         r   = ($urandom_range(0, 99) < 15);
         c   = ($urandom_range(0, 99) < 15);
         j   = ($urandom_range(0, 99) < 10);
         b   = ($urandom_range(0, 99) < 15);
         inc = ($urandom_range(0, 99) < 40);
         po  = ($urandom_range(0, 99) < 50);
         clr = ($urandom_range(0, 99) < 5);
         cycle(r, c, j, b, inc, po, clr, 8'($urandom_range(0, 255)));
      end
      idle(0);
      mid_reset();

      // Drain the scoreboard within a bounded number of cycles
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the Hmmm core, successor to the basic increment/jump counter. Holds the instruction address, supports increment, absolute jump, signed relative branch, and call/return through an internal return-address stack. Sits between the control unit and the shared data bus. It drives its value onto the bus on request and loads jump, branch and call operands from the bus.

## Interface
Parameters:
- ADDR_W, 8, width of the program counter; all PC arithmetic is modulo 2^ADDR_W.
- DATA_W, 16, width of the shared data bus; must be ≥ ADDR_W.
- STACK_DEPTH, 4, number of return-address entries; ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- increment  input  1  PC ← PC+1.
- jump  input  1  PC ← data[ADDR_W-1:0].
- branch  input  1  PC ← PC + signed data[ADDR_W-1:0].
- call  input  1  push PC+1, then PC ← data[ADDR_W-1:0].
- ret  input  1  PC ← popped top of stack.
- pc_out  input  1  request to drive the PC onto the bus.
- clr_err  input  1  clears the sticky error flags.
- data  inout  DATA_W  shared bus; driven with {zero-extend, PC} when enabled, otherwise Z.
- pc  output  ADDR_W  current PC, registered.
- stack_empty  output  1  no entries on the return stack.
- stack_full  output  1  STACK_DEPTH entries on the return stack.
- err_ovf  output  1  sticky; set when a call is attempted while the stack is full.
- err_unf  output  1  sticky; set when a ret is attempted while the stack is empty.

## Operation
- Reset (rst low, any time, asynchronous):
  - pc = 0, stack pointer = 0, stack_empty = 1, stack_full = 0.
  - err_ovf = err_unf = 0; data released to Z.
  - Stack contents are not cleared; they are don't-care.
- Command priority, one command per cycle: ret > call > jump > branch > increment. Lower-priority commands asserted in the same cycle are ignored. With no command asserted, PC holds.
- Bus drive:
  - data is driven only when pc_out = 1 and jump, branch and call are all 0.
  - If any of those three is asserted, the bus is treated as an input and pc_out is suppressed, so the PC never contends with an operand.
- Branch:
  - The offset is data[ADDR_W-1:0], interpreted as two's complement.
  - The result is taken relative to the current PC (not PC+1) and wraps modulo 2^ADDR_W.
- Call:
  - If the stack is not full: stack[sp] ← PC+1 (wrapped), sp ← sp+1, PC ← target.
  - If the stack is full: PC and stack are unchanged and err_ovf is set.
- Ret:
  - If the stack is not empty: sp ← sp-1, PC ← stack[sp-1].
  - If the stack is empty: PC is unchanged and err_unf is set.
- Errors:
  - err_ovf and err_unf are sticky until clr_err or reset.
  - If clr_err is asserted in the same cycle as a new error, the new error wins and the flag stays set.
- Increment wraps: PC = 2^ADDR_W-1 → 0.
- stack_empty = (sp == 0) and stack_full = (sp == STACK_DEPTH), both derived from the registered sp.

## Timing
- The new PC is visible on pc one cycle after the command edge.
- Bus drive is combinational from pc_out, the command inputs and the registered PC.
  - Asserting pc_out in the same cycle as increment shows the pre-increment value.
- Operands on data are sampled at the command's rising edge and must be stable for setup before that edge.
- stack_empty and stack_full update in the cycle after a push or pop.
- Back-to-back call then ret on consecutive cycles returns to call-site+1 with no bubble.
- Reset mid-operation:
  - Asserting rst overrides any command immediately.
  - After rst deasserts, the first edge with a command acts from PC = 0.

## Test plan
- Reset and increment:
  - Stimulus: pulse rst low, then increment for 3 cycles with pc_out = 1.
  - Required: pc = 0 after reset; bus reads 0, 1, 2 (pre-increment, one per cycle); bus is Z whenever pc_out = 0.
- Jump and suppression:
  - Stimulus: PC = 5, drive bus = 42 with jump = 1 and pc_out = 1.
  - Required: the PC does not drive the bus; pc = 42 next cycle.
- Branch with wrap, ADDR_W = 8:
  - At PC = 10 with offset 0xFB (-5): pc = 5.
  - At PC = 250 with offset +10: pc = 4.
- Call/return nesting, STACK_DEPTH = 4:
  - Stimulus: calls from PC 3, 20, 40, 60 to targets 20, 40, 60, 80.
  - Required: stack_full = 1; four rets give pc = 61, 41, 21, 4; then stack_empty = 1.
- Overflow and underflow:
  - A 5th call while full: pc is unchanged and err_ovf = 1.
  - A ret while empty: pc is unchanged and err_unf = 1.
  - Both flags persist until clr_err; a simultaneous new error plus clr_err keeps the flag at 1.
- Priority and async reset:
  - ret + call + increment in one cycle performs ret only.
  - rst asserted mid-cycle between edges drops pc to 0 immediately, without waiting for a clock edge.
